cla_serial_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 25 ++
 rtl/carry_lookahead_4.sv | 38 +++
 rtl/cla_serial_adder.sv | 126 ++++++++++++
 tb/tb_cla_serial_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, state encoding and overflow helper for the
//            nibble-serial carry-lookahead adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_lookahead_4.sv
`default_nettype none
// ============================================================================
// Module   : carry_lookahead_4
// Purpose  : Combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
module carry_lookahead_4
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] w_p;
    logic [NIB_W-1:0] w_g;
    logic [NIB_W:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is flattened to two levels of logic from g/p and cin.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[NIB_W-1:0];
    assign cout = w_c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_serial_adder
// Purpose  : WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per
//            clock, with valid/ready handshakes on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
            $error("cla_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [NIB_W-1:0] w_a_nibs [NIB];
    logic [NIB_W-1:0] w_b_nibs [NIB];
    logic [NIB_W-1:0] w_s;
    logic             w_cout;
    logic             w_last;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign w_a_nibs[gi] = r_a[gi*NIB_W +: NIB_W];
            assign w_b_nibs[gi] = r_b[gi*NIB_W +: NIB_W];
        end
    endgenerate

    carry_lookahead_4 u_cla (
        .a    (w_a_nibs[r_cnt]),
        .b    (w_b_nibs[r_cnt]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last = (r_cnt == CNT_W'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_cnt   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
            end
        end else if (r_state == RUN) begin
            for (int k = 0; k < NIB; k++) begin
                if (r_cnt == CNT_W'(k)) r_sum[k*NIB_W +: NIB_W] <= w_s;
            end
            r_carry <= w_cout;
            if (w_last) begin
                // w_s[3] is the final sum MSB, written on this same edge.
                r_cout <= w_cout;
                r_ovf  <= signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_s[NIB_W-1]);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_serial_adder
// Purpose  : Directed self-checking bench for cla_serial_adder (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    cla_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises, bounded; returns the count.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    // Single operation with out_ready held high; expects a 4-edge latency.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec,
                         input logic eo);
        int lat;
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(tag, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        tick();
        chk({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, overflow}), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("carry_nib", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held while consumer stalls, new operands ignored.
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 16'h0001; b = 16'h0001;
        wait_valid("bp", lat);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 32'({out_valid, in_ready, cout, overflow, sum}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 16'hBCDE}));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
        do_op("bp_next", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Reset asserted after two nibble edges aborts the operation.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'({out_valid, in_ready, cout}), 32'b010);
        chk("abort_sum", 32'(sum), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_no_result", 32'({out_valid, in_ready}), 32'b01);
        do_op("post_abort", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Back-to-back with in_valid held high across both operations.
        a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 16'h0001; b = 16'h0002; cin = 1'b0;
        wait_valid("b2b_1", lat);
        chk("b2b_1_lat", 32'(lat), 32'd4);
        chk("b2b_1_res", 32'({cout, overflow, sum}), 32'({1'b1, 1'b0, 16'h0000}));
        tick();
        chk("b2b_gap", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_2_accept", 32'(in_ready), 32'd0);
        wait_valid("b2b_2", lat);
        chk("b2b_2_lat", 32'(lat), 32'd4);
        chk("b2b_2_res", 32'({cout, overflow, sum}), 32'({1'b0, 1'b0, 16'h0003}));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
